// File: rtl/btp_pkg.sv
// Shared types for the branch target predictor: counter encodings and the entry record.
// BTP_SAT_COUNTER_EN selects a 2-bit saturating counter per entry instead of a single taken bit.
package btp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } btp_ctr_e;

`ifdef BTP_SAT_COUNTER_EN
  typedef btp_ctr_e btp_dir_t;
  localparam btp_dir_t DIR_INIT = SNT;
`else
  typedef logic btp_dir_t;
  localparam btp_dir_t DIR_INIT = 1'b0;
`endif

  typedef struct packed {
    logic     valid;
    btp_dir_t dir;
  } btp_entry_t;

  // The predicted direction is the counter MSB, or the bit itself in single-bit mode.
  function automatic logic dir_taken(input btp_dir_t d);
`ifdef BTP_SAT_COUNTER_EN
    logic [1:0] v;
    v = d;
    return v[1];
`else
    return d;
`endif
  endfunction

endpackage

// File: rtl/btp_sat_counter.sv
// Per-entry 2-bit saturating direction counter; loaded on allocation, trained on update hits.
module btp_sat_counter
  import btp_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     load_taken,
  input  logic     train,
  input  logic     taken,
  output btp_ctr_e state
);

  btp_ctr_e next_state;

  always_comb begin
    next_state = state;
    if (load) begin
      next_state = load_taken ? WT : WNT;
    end else if (train) begin
      case (state)
        SNT:     next_state = taken ? WNT : SNT;
        WNT:     next_state = taken ? WT  : SNT;
        WT:      next_state = taken ? ST  : WNT;
        ST:      next_state = taken ? ST  : WT;
        default: next_state = SNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SNT;
    else        state <= next_state;
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Fully-associative branch target buffer with registered lookup and read-before-write update.
// Define BTP_SAT_COUNTER_EN for 2-bit saturating direction counters; otherwise one taken bit per entry.
module branch_target_predictor
  import btp_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              lkp_valid,
  input  logic [ADDR_W-1:0] lkp_pc,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_target,
  output logic              rsp_taken,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [ADDR_W-1:0]  pc_q  [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  btp_dir_t           dir_q [ENTRIES];
  btp_entry_t         entry [ENTRIES];
  logic [IDX_W-1:0]   victim_q;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      entry[i] = '{valid: valid_q[i], dir: dir_q[i]};
    end
  end

  logic              lkp_hit;
  logic              lkp_taken;
  logic [ADDR_W-1:0] lkp_target;

  // At most one entry can match, so the last match found is the only one.
  always_comb begin
    lkp_hit    = 1'b0;
    lkp_taken  = 1'b0;
    lkp_target = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entry[i].valid && pc_q[i] == lkp_pc) begin
        lkp_hit    = 1'b1;
        lkp_taken  = dir_taken(entry[i].dir);
        lkp_target = tgt_q[i];
      end
    end
  end

  logic             upd_hit;
  logic             any_free;
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             do_write;
  logic             do_alloc;
  logic             use_victim;

  always_comb begin
    upd_hit  = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entry[i].valid && pc_q[i] == upd_pc) begin
        upd_hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!entry[i].valid && !any_free) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    do_write   = upd_valid && !flush;
    do_alloc   = do_write && !upd_hit;
    use_victim = do_alloc && !any_free;
    wr_idx     = upd_hit ? hit_idx : (any_free ? free_idx : victim_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      victim_q <= '0;
    end else if (flush) begin
      valid_q  <= '0;
      victim_q <= '0;
    end else begin
      if (do_alloc) valid_q[wr_idx] <= 1'b1;
      if (use_victim) begin
        victim_q <= (victim_q == IDX_W'(ENTRIES - 1)) ? '0 : victim_q + 1'b1;
      end
    end
  end

  // Tag and target storage carries no reset; the valid bits guard it.
  always_ff @(posedge clk) begin
    if (do_write) begin
      pc_q[wr_idx]  <= upd_pc;
      tgt_q[wr_idx] <= upd_target;
    end
  end

`ifdef BTP_SAT_COUNTER_EN
  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    btp_sat_counter u_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (do_alloc && wr_idx == IDX_W'(g)),
      .load_taken (upd_taken),
      .train      (do_write && upd_hit && wr_idx == IDX_W'(g)),
      .taken      (upd_taken),
      .state      (dir_q[g])
    );
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) dir_q[i] <= DIR_INIT;
    end else if (do_write) begin
      dir_q[wr_idx] <= upd_taken;
    end
  end
`endif

  // A lookup in the flush cycle must miss even though it reads pre-flush contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_target <= '0;
      rsp_taken  <= 1'b0;
    end else begin
      rsp_valid  <= lkp_valid;
      rsp_hit    <= lkp_valid && !flush && lkp_hit;
      rsp_target <= (lkp_valid && !flush && lkp_hit) ? lkp_target : '0;
      rsp_taken  <= lkp_valid && !flush && lkp_hit && lkp_taken;
    end
  end

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, meaning number of fully-associative entries (power of two, 2..64).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning PC and target width in bits.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning the reset: asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1, meaning invalidate all entries.
REQ-006 SHALL have port lkp_valid, input, 1, meaning a lookup request this cycle.
REQ-007 SHALL have port lkp_pc, input, ADDR_W, meaning the fetch PC to look up.
REQ-008 SHALL have port rsp_valid, output, 1, meaning the lookup response is valid (one cycle after lkp_valid).
REQ-009 SHALL have port rsp_hit, output, 1, meaning the looked-up PC was found in a valid entry.
REQ-010 SHALL have port rsp_target, output, ADDR_W, meaning the stored target on hit, else zero.
REQ-011 SHALL have port rsp_taken, output, 1, meaning the predicted direction on hit, else 0.
REQ-012 SHALL have port upd_valid, input, 1, meaning a resolved branch update this cycle.
REQ-013 SHALL have port upd_pc, input, ADDR_W, meaning the resolved branch PC.
REQ-014 SHALL have port upd_target, input, ADDR_W, meaning the resolved branch target.
REQ-015 SHALL have port upd_taken, input, 1, meaning the resolved branch direction.

Function
REQ-016 Lookup SHALL be registered: the response to the lkp_pc sampled at edge N SHALL appear on the rsp_* ports after edge N and hold until the next edge.
REQ-017 Outputs SHALL be rsp_valid=0, rsp_hit=0, rsp_target=0 and rsp_taken=0 whenever there is no lookup response.
REQ-018 A hit SHALL require the entry's valid bit set and its stored PC equal to lkp_pc; at most one entry SHALL ever match a given PC.
REQ-019 On an update that hits, the entry's target SHALL be overwritten and its direction state trained by upd_taken.
REQ-020 On an update that misses, the entry to overwrite SHALL be the lowest-index invalid entry if one exists, else the round-robin victim pointer.
REQ-021 The victim pointer SHALL advance by 1 on each allocation that uses it, and SHALL wrap from ENTRIES-1 to 0.
REQ-022 A new allocation SHALL store valid=1, upd_pc, upd_target, and initial direction state from upd_taken.
REQ-023 When lookup and update fall in the same cycle, the lookup SHALL see the pre-update contents (read-before-write).
REQ-024 flush SHALL clear all valid bits at the next edge and SHALL take priority over a same-cycle update; the victim pointer SHALL reset to 0.
REQ-025 A lookup issued in the flush cycle SHALL return rsp_hit=0.

Reset
REQ-026 On rst_n low, asynchronously: all valid bits=0, victim pointer=0, all direction state to initial not-taken, all rsp_* outputs=0.
REQ-027 Stored PC and target fields SHALL need no reset.

Configuration
REQ-028 Macro BTP_SAT_COUNTER_EN defined: each entry SHALL hold a 2-bit saturating counter (00..11).
REQ-029 With the macro, rsp_taken SHALL equal counter bit 1; training SHALL increment on taken and decrement on not-taken, saturating at 11 and 00.
REQ-030 With the macro, allocation SHALL initialise the counter to 10 if upd_taken=1, else to 01.
REQ-031 Macro undefined: each entry SHALL hold a single taken bit, overwritten by upd_taken on every update; rsp_taken SHALL equal that bit.

Structure
REQ-032 Package btp_pkg SHALL hold the counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the entry record typedef.
REQ-033 The saturating counter SHALL be a sub-module, btp_sat_counter, instantiated per entry only when BTP_SAT_COUNTER_EN is defined.

Verification
REQ-034 Reset, then lookup at 0x100 SHALL give rsp_valid=1 and rsp_hit=0 the next cycle.
REQ-035 Update (0x100, 0x200, taken), then lookup at 0x100 SHALL give hit=1, target=0x200, taken=1.
REQ-036 With macro, after allocate-taken, three not-taken updates at 0x100 SHALL step the counter 10→01→00→00 with rsp_taken=0 from the first onward; a later taken update SHALL read 01, rsp_taken=0.
REQ-037 Nine distinct PCs 0x0,0x4,…,0x20 into ENTRIES=8 SHALL evict entry 0; lookup 0x0 SHALL miss and lookup 0x20 SHALL hit.
REQ-038 Same-cycle lookup and update at new PC 0x300 SHALL give a miss; a lookup at 0x300 the following cycle SHALL hit.
REQ-039 Same-cycle flush and update (0x400) SHALL leave 0x400 and all prior PCs missing; asserting rst_n low mid-stream SHALL drive rsp_* to 0 immediately.
